decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder; generational successor to the team's fixed 1/2/3-bit enable decoders.
- Two modes:
  - Direct: select loaded through a valid/ready handshake.
  - Scan: the active output walks round-robin through all lines, with a programmable dwell time per line.
- Drives row/column strobes, chip-selects and mux enables where a glitch-free, registered one-hot select is required.

Parameters:
- SEL_W, 3, select width; output width is 2^SEL_W.
- DWELL_W, 8, width of the dwell-count input.
- ACTIVE_LOW, 0, 1 = outputs active-low (inactive level all-ones).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low forces all outputs inactive.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  direct-mode select valid.
- in_sel  in  SEL_W  direct-mode select index.
- in_ready  out  1  handshake ready; combinational, equals en & ~mode.
- dwell  in  DWELL_W  scan hold count; each line is held for dwell+1 cycles.
- q  out  2^SEL_W  registered one-hot decode (polarity per ACTIVE_LOW).
- cur_sel  out  SEL_W  registered index of the active line.
- q_valid  out  1  high when q carries an active line.
- wrap  out  1  one-cycle pulse when scan advances from 2^SEL_W-1 to 0.

Behaviour:
- Reset (async assert, sync release):
  - q inactive (all-0, or all-1 if ACTIVE_LOW).
  - cur_sel=0, q_valid=0, wrap=0, dwell counter=0, state IDLE.
- States:
  - IDLE: no line active.
  - HOLD: a line is active and static.
  - SCAN: a line is active and advancing.
- en=0 in any state: next cycle q inactive, q_valid=0, wrap=0, state IDLE; cur_sel retains its value. in_valid is ignored.
- Direct accept: en=1, mode=0, in_valid=1.
  - Next cycle: q=onehot(in_sel), cur_sel=in_sel, q_valid=1, state HOLD. Latency 1 cycle.
  - Back-to-back accepts update every cycle.
  - Without in_valid, HOLD keeps the current line.
- Scan entry: en=1, mode=1, from IDLE or HOLD.
  - Next cycle: cur_sel=0, q=onehot(0), q_valid=1, counter=0, state SCAN.
- SCAN, each cycle:
  - If counter >= dwell: cur_sel <= cur_sel+1 mod 2^SEL_W, counter <= 0.
  - Otherwise counter <= counter+1.
  - dwell is compared live. Reducing dwell below the counter advances on the next cycle; it never wraps the counter.
- dwell=0: advance every cycle; full sweep takes 2^SEL_W cycles.
- wrap: registered, high for exactly the cycle in which cur_sel becomes 0 through advance. Never high on scan entry.
- Mode change:
  - SCAN with mode->0: freeze the current line, state HOLD, in_ready=1 the same cycle. A same-cycle in_valid is accepted normally.
  - HOLD with mode->1: scan restarts at line 0 as on scan entry.
- in_valid with mode=1: ignored, no state change.
- Invariant: q is always exactly one-hot (or all-inactive when q_valid=0) on every cycle. No two lines are ever simultaneously active, including across mode and enable transitions.
- Asynchronous reset mid-scan: outputs go inactive immediately, without waiting for a clock edge.

Decomposition:
- Shared package decoder_pkg holds:
  - mode constants MODE_DIRECT=0, MODE_SCAN=1.
  - state enum {IDLE, HOLD, SCAN}.
  - a function onehot_w(SEL_W) returning 2^SEL_W.
- One natural sub-module: decoder_onehot, purely combinational, parametrised SEL_W, with an enable input. It generalises the existing fixed-width decoders and feeds the output register.

Test Plan:
- Reset, then direct accept in_sel=5 (SEL_W=3) -> one cycle later q=8'b0010_0000, cur_sel=5, q_valid=1, in_ready=1 throughout.
- mode=1, dwell=2 -> q=onehot(0) for 3 cycles, then onehot(1) for 3 cycles, ... onehot(7). Then q=onehot(0) with wrap=1 for exactly 1 cycle; one full sweep takes 24 cycles.
- mode=1, dwell=0 -> line advances every cycle; wrap pulses every 8 cycles. Check one-hot on every cycle.
- Mid-scan at cur_sel=3: mode->0 with in_valid=1, in_sel=6 -> in_ready=1 that cycle; next cycle q=onehot(6), state HOLD, no wrap.
- en dropped during SCAN at cur_sel=4 -> next cycle q=0, q_valid=0, cur_sel=4. Raise en with mode=1 -> restart at line 0.
- ACTIVE_LOW=1, SEL_W=4 build: reset gives q=16'hFFFF. Direct in_sel=15 -> q=16'h7FFF. Assert rst_n low mid-scan -> q=16'hFFFF before the next clk edge.

Source files
------------

// File: rtl/decoder_pkg.sv
// +--------------------------------------------------------------------------+
// | decoder_pkg: shared mode constants, state encoding and width helper.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  function automatic int onehot_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_scan_if.sv
// +--------------------------------------------------------------------------+
// | decoder_scan_if: select handshake, scan control and decoded outputs.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface decoder_scan_if
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);

  logic                        en;
  logic                        mode;
  logic                        in_valid;
  logic [SEL_W-1:0]            in_sel;
  logic                        in_ready;
  logic [DWELL_W-1:0]          dwell;
  logic [onehot_w(SEL_W)-1:0]  q;
  logic [SEL_W-1:0]            cur_sel;
  logic                        q_valid;
  logic                        wrap;

  modport master (
    output en, mode, in_valid, in_sel, dwell,
    input  in_ready, q, cur_sel, q_valid, wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel, dwell,
    output in_ready, q, cur_sel, q_valid, wrap
  );

endinterface

`default_nettype wire

// File: rtl/decoder_onehot.sv
// +--------------------------------------------------------------------------+
// | decoder_onehot: combinational SEL_W-to-2^SEL_W active-high decoder.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  wire logic                       en,
  input  wire logic [SEL_W-1:0]           sel,
  output logic      [onehot_w(SEL_W)-1:0] onehot
);

  for (genvar i = 0; i < onehot_w(SEL_W); i++) begin : g_line
    assign onehot[i] = en && (sel == SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/decoder_scan.sv
// +--------------------------------------------------------------------------+
// | decoder_scan: registered one-hot decoder with direct load and scan mode. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  decoder_scan_if.slave bus
);

  localparam int                c_lines  = onehot_w(SEL_W);
  localparam logic [c_lines-1:0] c_invert = {c_lines{ACTIVE_LOW}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [DWELL_W-1:0]   r_cnt;
  logic [DWELL_W-1:0]   w_cnt_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic                 r_q_valid;
  logic                 w_active_nxt;
  logic [c_lines-1:0]   r_q;
  logic [c_lines-1:0]   w_dec;
  logic                 w_scan_mode;

  assign w_scan_mode  = (bus.mode == MODE_SCAN);
  assign bus.in_ready = bus.en && (bus.mode == MODE_DIRECT);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;

    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_scan_mode) begin
      if (r_state != SCAN) begin
        w_state_nxt = SCAN;
        w_sel_nxt   = '0;
        w_cnt_nxt   = '0;
      end else if (r_cnt >= bus.dwell) begin
        // Live compare: a dwell lowered beneath the count advances at once.
        w_sel_nxt  = r_sel + SEL_W'(1);
        w_cnt_nxt  = '0;
        w_wrap_nxt = &r_sel;
      end else begin
        w_cnt_nxt = r_cnt + DWELL_W'(1);
      end
    end else begin
      w_cnt_nxt = '0;
      if (bus.in_valid) begin
        w_state_nxt = HOLD;
        w_sel_nxt   = bus.in_sel;
      end else if (r_state == SCAN) begin
        w_state_nxt = HOLD;
      end
    end
  end

  assign w_active_nxt = (w_state_nxt != IDLE);

  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .en     (w_active_nxt),
    .sel    (w_sel_nxt),
    .onehot (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output flops hold the decoded line so q never passes through two hot bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= c_invert;
      r_q_valid <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_q       <= w_dec ^ c_invert;
      r_q_valid <= w_active_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign bus.q       = r_q;
  assign bus.cur_sel = r_sel;
  assign bus.q_valid = r_q_valid;
  assign bus.wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// +--------------------------------------------------------------------------+
// | tb_decoder_scan: directed checks of decoder_scan in two configurations.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decoder_scan;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_na;
  logic rst_nb;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) bus_a ();
  decoder_scan_if #(.SEL_W(4), .DWELL_W(8)) bus_b ();

  decoder_scan #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_na),
    .bus   (bus_a.slave)
  );

  decoder_scan #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel;

    rst_na = 1'b0;
    rst_nb = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.in_valid = 1'b0;
    bus_a.in_sel = '0; bus_a.dwell = '0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.in_valid = 1'b0;
    bus_b.in_sel = '0; bus_b.dwell = '0;

    repeat (2) tick();
    chk("rst_q",       bus_a.q,       32'h00);
    chk("rst_cur_sel", bus_a.cur_sel, 32'd0);
    chk("rst_q_valid", bus_a.q_valid, 32'd0);
    chk("rst_wrap",    bus_a.wrap,    32'd0);
    rst_na = 1'b1;

    // Direct accept of line 5
    bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_sel = 3'd5;
    #1 chk("dir_ready", bus_a.in_ready, 32'd1);
    tick();
    chk("dir5_q",       bus_a.q,        32'h20);
    chk("dir5_cur_sel", bus_a.cur_sel,  32'd5);
    chk("dir5_q_valid", bus_a.q_valid,  32'd1);
    chk("dir5_ready",   bus_a.in_ready, 32'd1);
    bus_a.in_valid = 1'b0;
    tick();
    chk("hold5_q", bus_a.q, 32'h20);

    // Back-to-back accepts
    bus_a.in_valid = 1'b1; bus_a.in_sel = 3'd2;
    tick();
    chk("b2b2_q", bus_a.q, 32'h04);
    bus_a.in_sel = 3'd7;
    tick();
    chk("b2b7_q", bus_a.q, 32'h80);
    bus_a.in_valid = 1'b0;

    // Scan with dwell=2: three cycles per line, wrap after 24 cycles
    bus_a.mode = 1'b1; bus_a.dwell = 8'd2;
    #1 chk("scan_ready", bus_a.in_ready, 32'd0);
    tick();
    chk("entry_q",    bus_a.q,       32'h01);
    chk("entry_sel",  bus_a.cur_sel, 32'd0);
    chk("entry_wrap", bus_a.wrap,    32'd0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_sel = (k / 3) % 8;
      chk($sformatf("d2_q_%0d", k),    bus_a.q,    32'd1 << exp_sel);
      chk($sformatf("d2_wrap_%0d", k), bus_a.wrap, (k == 24) ? 32'd1 : 32'd0);
    end

    // Dwell lowered to 0 below the running count: advance every cycle
    bus_a.dwell = 8'd0;
    for (int j = 1; j <= 19; j++) begin
      tick();
      chk($sformatf("d0_q_%0d", j),    bus_a.q,    32'd1 << (j % 8));
      chk($sformatf("d0_wrap_%0d", j), bus_a.wrap, ((j % 8) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("d0_hot_%0d", j),  $countones(bus_a.q), 32'd1);
    end
    chk("pre_switch_sel", bus_a.cur_sel, 32'd3);

    // Leave scan at line 3 with a same-cycle accept of line 6
    bus_a.mode = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_sel = 3'd6;
    #1 chk("switch_ready", bus_a.in_ready, 32'd1);
    tick();
    chk("switch_q",       bus_a.q,       32'h40);
    chk("switch_sel",     bus_a.cur_sel, 32'd6);
    chk("switch_wrap",    bus_a.wrap,    32'd0);
    chk("switch_q_valid", bus_a.q_valid, 32'd1);
    bus_a.in_valid = 1'b0;

    // Restart scan, drop en at line 4
    bus_a.mode = 1'b1; bus_a.dwell = 8'd0;
    tick();
    chk("rescan_q", bus_a.q, 32'h01);
    repeat (4) tick();
    chk("at4_q", bus_a.q, 32'h10);
    bus_a.en = 1'b0;
    #1 chk("en0_ready", bus_a.in_ready, 32'd0);
    tick();
    chk("en0_q",       bus_a.q,       32'h00);
    chk("en0_q_valid", bus_a.q_valid, 32'd0);
    chk("en0_sel",     bus_a.cur_sel, 32'd4);
    chk("en0_wrap",    bus_a.wrap,    32'd0);
    bus_a.en = 1'b1;
    tick();
    chk("en1_q",       bus_a.q,       32'h01);
    chk("en1_sel",     bus_a.cur_sel, 32'd0);
    chk("en1_q_valid", bus_a.q_valid, 32'd1);
    chk("en1_wrap",    bus_a.wrap,    32'd0);

    // in_valid during scan is ignored
    bus_a.dwell = 8'd5; bus_a.in_valid = 1'b1; bus_a.in_sel = 3'd6;
    tick();
    chk("ign_q",   bus_a.q,       32'h01);
    chk("ign_sel", bus_a.cur_sel, 32'd0);
    bus_a.in_valid = 1'b0;

    // Active-low, 4-bit select build
    chk("b_rst_q",       bus_b.q,       32'hFFFF);
    chk("b_rst_q_valid", bus_b.q_valid, 32'd0);
    rst_nb = 1'b1;
    bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_sel = 4'd15;
    tick();
    chk("b_dir15_q",   bus_b.q,       32'h7FFF);
    chk("b_dir15_sel", bus_b.cur_sel, 32'd15);
    bus_b.in_valid = 1'b0; bus_b.mode = 1'b1; bus_b.dwell = 8'd0;
    tick();
    chk("b_scan0_q", bus_b.q, 32'hFFFE);
    tick();
    chk("b_scan1_q", bus_b.q, 32'hFFFD);
    #3 rst_nb = 1'b0;
    #1;
    chk("b_arst_q",       bus_b.q,       32'hFFFF);
    chk("b_arst_q_valid", bus_b.q_valid, 32'd0);
    chk("b_arst_sel",     bus_b.cur_sel, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
